// File: rtl/ifu_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, AXI response codes,
// and the default boot PC.
package ifu_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_OUT  = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h3000_0000;

endpackage

// File: rtl/ifu_fetch_stage.sv
// Single-outstanding instruction fetch with static pc+4 prediction.
// AR/R read channel upstream, valid/ready to decode downstream, redirect from execute.
module ifu_fetch_stage
  import ifu_fetch_stage_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_predict_o,
  input  logic              control_hazard,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              fetch_err
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic [ADDR_W-1:0] seq_pc;
  logic              stale, stale_nxt;
  logic              latch;

  assign seq_pc = req_addr + ADDR_W'(4);

  assign araddr    = req_addr;
  assign arvalid   = (state == S_ADDR) && !rst;
  assign rready    = ((state == S_DATA) || (state == S_DROP)) && !rst;
  assign out_valid = (state == S_OUT) && !control_hazard && !rst;

  // stale marks an AR still on the bus that a redirect has already made wrong-path;
  // its response must be swallowed through S_DROP once the address is accepted.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    stale_nxt    = stale;
    latch        = 1'b0;
    case (state)
      S_ADDR: begin
        if (arready) begin
          state_nxt = (stale || control_hazard) ? S_DROP : S_DATA;
          stale_nxt = 1'b0;
        end else if (control_hazard) begin
          stale_nxt = 1'b1;
        end
      end
      S_DATA: begin
        if (rvalid && !control_hazard) begin
          latch     = 1'b1;
          pc_nxt    = seq_pc;
          state_nxt = S_OUT;
        end else if (rvalid) begin
          state_nxt = S_ADDR;
        end else if (control_hazard) begin
          state_nxt = S_DROP;
        end
      end
      S_OUT: begin
        if (control_hazard || out_ready) begin
          state_nxt    = S_ADDR;
          req_addr_nxt = pc;
        end
      end
      S_DROP: begin
        if (rvalid) begin
          state_nxt    = S_ADDR;
          req_addr_nxt = pc;
        end
      end
      default: state_nxt = S_ADDR;
    endcase
    // A redirect always retargets pc; req_addr only moves when a fresh request starts,
    // so an AR already waiting in S_ADDR keeps its address stable.
    if (control_hazard) begin
      pc_nxt = redirect_pc;
      if ((state_nxt == S_ADDR) && (state != S_ADDR))
        req_addr_nxt = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_ADDR;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      stale        <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
      pc_predict_o <= '0;
      fetch_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      stale    <= stale_nxt;
      if (latch) begin
        inst_o       <= rdata;
        pc_o         <= req_addr;
        pc_predict_o <= seq_pc;
        if (rresp != RESP_OKAY)
          fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Bench for ifu_fetch_stage: a latency-configurable memory responder plus a delivered-stream
// reference (next expected PC advances by 4 per delivery and jumps to the last redirect).
module tb_ifu_fetch_stage;

  localparam logic [31:0] RPC = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_valid, out_ready;
  logic [31:0] inst_o, pc_o, pc_predict_o;
  logic        control_hazard;
  logic [31:0] redirect_pc;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready, fetch_err;

  ifu_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_o(inst_o), .pc_o(pc_o), .pc_predict_o(pc_predict_o),
    .control_hazard(control_hazard), .redirect_pc(redirect_pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, deliveries = 0;

  // stimulus knobs, applied at the next negedge
  logic        rst_req = 1'b1, ch_req = 1'b0, ordy = 1'b1;
  logic [31:0] rpc_req = '0;
  logic [1:0]  resp_cfg = 2'b00;
  int          ar_lat = 0, r_lat = 0;
  bit          rnd_lat = 0;

  // memory responder state
  bit          r_pend = 0;
  logic [31:0] r_addr = '0;
  int          ar_cnt = 0, r_cnt = 0;

  // reference: PC the next delivered instruction must carry
  logic [31:0] exp_pc = RPC;

  // per-cycle samples
  bit          s_arhs, s_rhs, s_ohs, s_ovalid, s_arvalid, s_ferr;
  logic [31:0] s_araddr, s_inst, s_pc, s_pcp;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h3000_0413;
  endfunction

  task automatic cycle();
    @(negedge clk);
    rst            = rst_req;
    control_hazard = ch_req;
    redirect_pc    = rpc_req;
    out_ready      = ordy;
    if (!r_pend) begin
      arready = (ar_cnt >= ar_lat);
      rvalid  = 1'b0;
      rdata   = $urandom;
      rresp   = 2'b00;
    end else begin
      arready = 1'b0;
      rvalid  = (r_cnt >= r_lat);
      rdata   = rvalid ? mem_word(r_addr) : $urandom;
      rresp   = resp_cfg;
    end
    #1;
    s_arvalid = arvalid; s_araddr = araddr; s_ovalid = out_valid;
    s_arhs = arvalid && arready; s_rhs = rvalid && rready; s_ohs = out_valid && out_ready;
    s_inst = inst_o; s_pc = pc_o; s_pcp = pc_predict_o; s_ferr = fetch_err;
    if (rst) begin
      n_cmp++;
      if (out_valid !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_gate: out_valid=%b arvalid=%b rready=%b required all 0", out_valid, arvalid, rready);
      end
      exp_pc = RPC;
    end else begin
      if (prev_wait) begin
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== prev_addr) begin
          n_bad++;
          $display("FAIL ar_stable: arvalid=%b araddr=%h required 1 %h", arvalid, araddr, prev_addr);
        end
      end
      if (r_pend) begin
        n_cmp++;
        if (arvalid !== 1'b0) begin
          n_bad++;
          $display("FAIL no_overlap: arvalid=%b required 0 while read outstanding", arvalid);
        end
      end
      if (control_hazard) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL kill_valid: out_valid=%b required 0 during redirect", out_valid);
        end
      end
      if (s_ohs) begin
        n_cmp++;
        if (pc_o !== exp_pc || inst_o !== mem_word(exp_pc) || pc_predict_o !== exp_pc + 32'd4) begin
          n_bad++;
          $display("FAIL deliver: pc=%h inst=%h pred=%h required %h %h %h",
                   pc_o, inst_o, pc_predict_o, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (control_hazard) exp_pc = redirect_pc;
    end
    prev_wait = !rst && arvalid && !arready;
    prev_addr = araddr;
    @(posedge clk);
    if (rst) begin
      r_pend = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (s_arhs) begin
        r_pend = 1; r_addr = s_araddr; ar_cnt = 0; r_cnt = 0;
        if (rnd_lat) begin
          ar_lat = $urandom_range(0, 3);
          r_lat  = $urandom_range(0, 3);
        end
      end else if (s_arvalid) begin
        ar_cnt++;
      end
      if (s_rhs) r_pend = 0;
      else if (r_pend && !s_arhs) r_cnt++;
    end
    ch_req = 1'b0;
  endtask

  task automatic wait_deliver(input int max, output bit ok);
    ok = 0;
    ordy = 1'b1;
    for (int i = 0; i < max && !ok; i++) begin
      cycle();
      ok = s_ohs;
    end
  endtask

  task automatic test_reset();
    rst_req = 1'b1; ordy = 1'b1; ar_lat = 0; r_lat = 0; rnd_lat = 0; resp_cfg = 2'b00;
    repeat (3) cycle();
    n_cmp++;
    if (s_inst !== 32'd0 || s_pc !== 32'd0 || s_pcp !== 32'd0 || s_ferr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_regs: inst=%h pc=%h pred=%h err=%b required 0", s_inst, s_pc, s_pcp, s_ferr);
    end
    rst_req = 1'b0;
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== RPC || s_arhs !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_ar: arvalid=%b araddr=%h hs=%b required 1 %h 1", s_arvalid, s_araddr, s_arhs, RPC);
    end
  endtask

  task automatic test_basic_latency();
    cycle();
    n_cmp++;
    if (s_rhs !== 1'b1 || s_ovalid !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_r: rhs=%b out_valid=%b required 1 0", s_rhs, s_ovalid);
    end
    cycle();
    n_cmp++;
    if (s_ohs !== 1'b1 || s_pc !== RPC || s_pcp !== RPC + 32'd4 || s_inst !== 32'h0000_0413) begin
      n_bad++;
      $display("FAIL lat_out: hs=%b pc=%h pred=%h inst=%h required 1 %h %h 00000413",
               s_ohs, s_pc, s_pcp, s_inst, RPC, RPC + 32'd4);
    end
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== RPC + 32'd4) begin
      n_bad++;
      $display("FAIL lat_next_ar: arvalid=%b araddr=%h required 1 %h", s_arvalid, s_araddr, RPC + 32'd4);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h_inst, h_pc;
    int i;
    ordy = 1'b0;
    for (i = 0; i < 10; i++) begin
      cycle();
      if (s_ovalid) break;
    end
    n_cmp++;
    if (!s_ovalid) begin
      n_bad++;
      $display("FAIL bp_valid_timeout: out_valid=0 required 1 within 10 cycles");
    end
    h_inst = s_inst; h_pc = s_pc;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++;
      if (s_ovalid !== 1'b1 || s_arvalid !== 1'b0 || s_inst !== h_inst || s_pc !== h_pc) begin
        n_bad++;
        $display("FAIL bp_hold: valid=%b arvalid=%b inst=%h pc=%h required 1 0 %h %h",
                 s_ovalid, s_arvalid, s_inst, s_pc, h_inst, h_pc);
      end
    end
    ordy = 1'b1;
    cycle();
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== h_pc + 32'd4) begin
      n_bad++;
      $display("FAIL bp_resume: arvalid=%b araddr=%h required 1 %h", s_arvalid, s_araddr, h_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_data();
    bit ok;
    r_lat = 3;
    ch_req = 1'b1; rpc_req = 32'h3000_0100;
    cycle();
    n_cmp++;
    if (s_rhs !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_early_r: rhs=%b required 0", s_rhs);
    end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      ok = s_rhs;
      n_cmp++;
      if (s_ovalid !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_drop_valid: out_valid=%b required 0", s_ovalid);
      end
    end
    r_lat = 0;
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000_0100) begin
      n_bad++;
      $display("FAIL rd_restart: arvalid=%b araddr=%h required 1 30000100", s_arvalid, s_araddr);
    end
    wait_deliver(10, ok);
    n_cmp++;
    if (!ok || s_pc !== 32'h3000_0100) begin
      n_bad++;
      $display("FAIL rd_deliver: got=%b pc=%h required 1 30000100", ok, s_pc);
    end
  endtask

  task automatic test_redirect_out();
    bit ok;
    ordy = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      ok = s_ovalid;
    end
    ordy = 1'b1; ch_req = 1'b1; rpc_req = 32'h3000_0040;
    cycle();
    n_cmp++;
    if (!ok || s_ovalid !== 1'b0 || s_ohs !== 1'b0) begin
      n_bad++;
      $display("FAIL ro_kill: reached=%b out_valid=%b hs=%b required 1 0 0", ok, s_ovalid, s_ohs);
    end
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000_0040) begin
      n_bad++;
      $display("FAIL ro_restart: arvalid=%b araddr=%h required 1 30000040", s_arvalid, s_araddr);
    end
    wait_deliver(10, ok);
    n_cmp++;
    if (!ok || s_pc !== 32'h3000_0040) begin
      n_bad++;
      $display("FAIL ro_deliver: got=%b pc=%h required 1 30000040", ok, s_pc);
    end
  endtask

  task automatic test_ar_stall();
    bit ok;
    ar_lat = 4;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (i == 2) begin ch_req = 1'b1; rpc_req = 32'h3000_0180; end
      cycle();
      ok = s_arhs;
      n_cmp++;
      if (s_araddr !== 32'h3000_0044) begin
        n_bad++;
        $display("FAIL as_addr_hold: araddr=%h required 30000044", s_araddr);
      end
    end
    ar_lat = 0; r_lat = 2;
    ch_req = 1'b1; rpc_req = 32'h3000_0200;
    cycle();
    n_cmp++;
    if (!ok || s_rhs !== 1'b0) begin
      n_bad++;
      $display("FAIL as_handshake: got=%b rhs=%b required 1 0", ok, s_rhs);
    end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      ok = s_rhs;
      n_cmp++;
      if (s_ovalid !== 1'b0) begin
        n_bad++;
        $display("FAIL as_drop_valid: out_valid=%b required 0", s_ovalid);
      end
    end
    r_lat = 0;
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h3000_0200) begin
      n_bad++;
      $display("FAIL as_last_wins: arvalid=%b araddr=%h required 1 30000200", s_arvalid, s_araddr);
    end
    wait_deliver(10, ok);
    n_cmp++;
    if (!ok || s_pc !== 32'h3000_0200) begin
      n_bad++;
      $display("FAIL as_deliver: got=%b pc=%h required 1 30000200", ok, s_pc);
    end
  endtask

  task automatic test_resp_err();
    bit ok;
    resp_cfg = 2'b10;
    wait_deliver(10, ok);
    resp_cfg = 2'b00;
    n_cmp++;
    if (!ok || s_ferr !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: got=%b fetch_err=%b required 1 1", ok, s_ferr);
    end
    wait_deliver(10, ok);
    n_cmp++;
    if (!ok || s_ferr !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got=%b fetch_err=%b required 1 1", ok, s_ferr);
    end
    r_lat = 5;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      ok = s_arhs;
    end
    cycle();
    r_lat = 0;
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    n_cmp++;
    if (!ok || s_arvalid !== 1'b1 || s_araddr !== RPC || s_ferr !== 1'b0) begin
      n_bad++;
      $display("FAIL err_reset: got=%b arvalid=%b araddr=%h fetch_err=%b required 1 1 %h 0",
               ok, s_arvalid, s_araddr, s_ferr, RPC);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    ch_req = 1'b1; rpc_req = 32'hFFFF_FFFC;
    cycle();
    cycle();
    n_cmp++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL wrap_restart: arvalid=%b araddr=%h required 1 fffffffc", s_arvalid, s_araddr);
    end
    wait_deliver(10, ok);
    n_cmp++;
    if (!ok || s_pc !== 32'hFFFF_FFFC || s_pcp !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_pred: got=%b pc=%h pred=%h required 1 fffffffc 00000000", ok, s_pc, s_pcp);
    end
    wait_deliver(10, ok);
    n_cmp++;
    if (!ok || s_pc !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_next: got=%b pc=%h required 1 00000000", ok, s_pc);
    end
  endtask

  task automatic test_random();
    int idle = 0, d0;
    d0 = deliveries;
    rnd_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      ordy    = ($urandom_range(0, 3) != 0);
      ch_req  = ($urandom_range(0, 15) == 0);
      rpc_req = $urandom & 32'hFFFF_FFFC;
      cycle();
      if (s_ohs || control_hazard) idle = 0;
      else idle++;
      if (idle > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_progress: %0d cycles without delivery required <= 40", idle);
        break;
      end
    end
    rnd_lat = 0; ar_lat = 0; r_lat = 0; ordy = 1'b1;
    n_cmp++;
    if (deliveries - d0 < 100 || s_ferr !== 1'b0) begin
      n_bad++;
      $display("FAIL rnd_summary: deliveries=%0d fetch_err=%b required >=100 0", deliveries - d0, s_ferr);
    end
  endtask

  initial begin
    rst = 1'b1; control_hazard = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    test_reset();
    test_basic_latency();
    test_backpressure();
    test_redirect_data();
    test_redirect_out();
    test_ar_stall();
    test_resp_err();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
